// File: rtl/tt_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// operand width and the uio pin map.
package tt_mult_pkg;

  localparam int unsigned N        = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BUSY_BIT = 1;
  localparam int unsigned DONE_BIT = 2;
  localparam int unsigned CNT_LSB  = 4;

  // Bits 1,2 and the count nibble drive out; bits 0 (start) and 3 stay inputs.
  localparam logic [7:0] UIO_OE_MASK = 8'b1111_0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tt_shift_add_dp.sv
// Shift-add datapath: operand registers, 2W-bit accumulator and iteration index.
// load captures operands and clears state; step performs one shift-add iteration.
module tt_shift_add_dp #(
  parameter int unsigned W = tt_mult_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] prod_c,
  output logic           last_c
);

  localparam int unsigned PROD_W = 2 * W;
  localparam int unsigned IDX_W  = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]      a_q,   a_d;
  logic [W-1:0]      b_q,   b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    if (load) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = '0;
      idx_d = '0;
    end else if (step) begin
      if (b_q[0]) begin
        acc_d = acc_q + (PROD_W'(a_q) << idx_q);
      end
      b_d   = b_q >> 1;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  // Next accumulator value, so the final product is available on the last step edge.
  assign prod_c = acc_d;
  assign last_c = (idx_q == IDX_W'(W - 1));

endmodule

// File: rtl/tt_mult_seq.sv
// Sequential unsigned multiplier: A=ui_in[3:0], B=ui_in[7:4], product on uo_out
// after N shift-add iterations; busy/done/completed-count on uio_out.
module tt_mult_seq #(
  parameter int unsigned N = tt_mult_pkg::N
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  import tt_mult_pkg::*;

  localparam int unsigned PROD_W = 2 * N;

  state_e            state_q, state_d;
  logic [PROD_W-1:0] prod_q,  prod_d;
  logic [CNT_W-1:0]  ops_q,   ops_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic              start_c;
  logic              load_c;
  logic              step_c;
  logic              last_c;
  logic [PROD_W-1:0] dp_prod_c;
  logic              unused_uio_c;

  assign start_c      = uio_in[0];
  assign unused_uio_c = ^uio_in[7:1];

  tt_shift_add_dp #(
    .W(N)
  ) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .step  (step_c),
    .a_in  (ui_in[N-1:0]),
    .b_in  (ui_in[2*N-1:N]),
    .prod_c(dp_prod_c),
    .last_c(last_c)
  );

  // Control: nothing moves unless ena is high; busy/done are registered from the next state.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    ops_d   = ops_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            load_c  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          step_c = 1'b1;
          if (last_c) begin
            prod_d  = dp_prod_c;
            state_d = DONE;
          end
        end
        DONE: begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prod_q  <= '0;
      ops_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      ops_q   <= ops_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    uio_out                      = '0;
    uio_out[BUSY_BIT]            = busy_q;
    uio_out[DONE_BIT]            = done_q;
    uio_out[CNT_LSB +: CNT_W]    = ops_q;
  end

  assign uo_out = 8'(prod_q);
  assign uio_oe = UIO_OE_MASK;

endmodule
